// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions: field constants, inverse FSM encoding and the
// shift-reduce-accumulate step used by the serial multipliers.
package gf8_pkg;

  localparam int unsigned GfWidth = 8;
  localparam logic [8:0]  GfPoly  = 9'h11B;
  localparam logic [7:0]  InvExp  = 8'hFE;

  typedef enum logic [1:0] {
    StIdle,
    StSqr,
    StMul,
    StFin
  } gf8_inv_state_e;

  // One MSB-first multiplier step: acc*x^1 mod poly, then add x if the operand bit is set.
  function automatic logic [7:0] gf8_mac_step(input logic [7:0] acc, input logic [7:0] x,
                                              input logic bit_set, input logic [8:0] poly);
    logic [8:0] sh;
    sh = {acc, 1'b0};
    if (sh[8]) sh = sh ^ poly;
    return sh[7:0] ^ (bit_set ? x : 8'h00);
  endfunction

endpackage

// File: rtl/gf8_mul_serial.sv
// Bit-serial GF(2^8) multiplier: one bit of y per cycle, MSB first.
// go loads the operands and performs the first step; rdy pulses when p is valid.
module gf8_mul_serial
  import gf8_pkg::*;
#(
  parameter logic [8:0] POLY = GfPoly
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [GfWidth-1:0] x,
  input  logic [GfWidth-1:0] y,
  output logic [GfWidth-1:0] p,
  output logic               rdy
);

  logic [7:0] xs_q, xs_d;
  logic [7:0] ys_q, ys_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic       rdy_q, rdy_d;

  always_comb begin
    xs_d  = xs_q;
    ys_d  = ys_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rdy_d = 1'b0;
    if (go) begin
      xs_d  = x;
      ys_d  = {y[6:0], 1'b0};
      acc_d = gf8_mac_step(8'h00, x, y[7], POLY);
      cnt_d = 3'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = gf8_mac_step(acc_q, xs_q, ys_q[7], POLY);
      ys_d  = {ys_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q  <= 8'h00;
      ys_q  <= 8'h00;
      acc_q <= 8'h00;
      cnt_q <= 3'd0;
      run_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      rdy_q <= rdy_d;
    end
  end

  assign p   = acc_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/gf8_inverse_seq.sv
// Sequential GF(2^8) inverter: a^254 by left-to-right square-and-multiply
// through one shared serial multiplier, fixed 105-cycle latency.
module gf8_inverse_seq
  import gf8_pkg::*;
#(
  parameter logic [8:0] POLY = GfPoly
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [GfWidth-1:0] a_in,
  output logic               busy,
  output logic               done,
  output logic [GfWidth-1:0] inv_out,
  output logic               zero_err
);

  gf8_inv_state_e state_q, state_d;
  logic [7:0] operand_q, operand_d;
  logic [2:0] bit_q, bit_d;
  logic       first_q, first_d;
  logic [7:0] inv_q, inv_d;
  logic       zerr_q, zerr_d;

  logic       mul_go;
  logic [7:0] mul_x, mul_y, mul_p;
  logic       mul_rdy;

  gf8_mul_serial #(
    .POLY(POLY)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (mul_go),
    .x   (mul_x),
    .y   (mul_y),
    .p   (mul_p),
    .rdy (mul_rdy)
  );

  // The running power lives in the multiplier output; each new product is
  // chained straight back in on the rdy cycle.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    bit_d     = bit_q;
    first_d   = first_q;
    inv_d     = inv_q;
    zerr_d    = zerr_q;
    mul_go    = 1'b0;
    mul_x     = mul_p;
    mul_y     = mul_p;
    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        if (start) begin
          state_d   = StSqr;
          operand_d = a_in;
          bit_d     = 3'(GfWidth - 2);
          first_d   = 1'b1;
        end
      end
      StSqr: begin
        if (first_q) begin
          first_d = 1'b0;
          mul_go  = 1'b1;
          mul_x   = operand_q;
          mul_y   = operand_q;
        end else if (mul_rdy) begin
          if (InvExp[bit_q]) begin
            state_d = StMul;
            mul_go  = 1'b1;
            mul_y   = operand_q;
          end else if (bit_q == 3'd0) begin
            state_d = StFin;
            inv_d   = mul_p;
            zerr_d  = (operand_q == 8'h00);
          end else begin
            bit_d  = bit_q - 3'd1;
            mul_go = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_rdy) begin
          state_d = StSqr;
          bit_d   = bit_q - 3'd1;
          mul_go  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      operand_q <= 8'h00;
      bit_q     <= 3'd0;
      first_q   <= 1'b0;
      inv_q     <= 8'h00;
      zerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      bit_q     <= bit_d;
      first_q   <= first_d;
      inv_q     <= inv_d;
      zerr_q    <= zerr_d;
    end
  end

  assign busy     = (state_q == StSqr) || (state_q == StMul);
  assign done     = (state_q == StFin);
  assign inv_out  = inv_q;
  assign zero_err = zerr_q;

endmodule

// File: doc/gf8_inverse_seq.md
GF8_INVERSE_SEQ -- requirements
Module: gf8_inverse_seq

Interface
REQ-001 Parameter POLY, default 9'h11B, field polynomial x^8+x^4+x^3+x+1.
REQ-002 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port start, input, 1, request to invert a_in; sampled only when busy=0.
REQ-005 Port a_in, input, 8, operand in GF(2^8), polynomial basis.
REQ-006 Port busy, output, 1, high from the cycle after start is accepted until done.
REQ-007 Port done, output, 1, one-cycle pulse when inv_out is valid.
REQ-008 Port inv_out, output, 8, multiplicative inverse of the captured operand.
REQ-009 Port zero_err, output, 1, high with done when the captured operand was 0x00.

Function
REQ-010 Block SHALL compute inv = a^254 mod POLY (Fermat), so that a*inv = 0x01 for every nonzero a.
REQ-011 Addition within the block SHALL be bitwise XOR; no carries at any width.
REQ-012 Start accepted when start=1 and busy=0; a_in captured into an operand register on that edge.
REQ-013 start while busy=1 SHALL be ignored; neither operand nor progress is affected.
REQ-014 Exponentiation SHALL be left-to-right square-and-multiply over exponent 8'b11111110: r=a; for bits 6..1: r=r^2 then r=r*a; for bit 0: r=r^2 only.
REQ-015 Exactly 13 field multiplications (7 squarings, 6 multiplies by a) SHALL be performed per operation, all through one shared serial multiplier.
REQ-016 Each multiplication SHALL take exactly 8 cycles (one operand bit per cycle, MSB first, shift-reduce-accumulate).
REQ-017 done SHALL rise exactly 105 cycles after the accepting edge (13x8 + 1), fixed, independent of operand value.
REQ-018 FSM states: IDLE, SQR, MUL, FIN; IDLE->SQR on accept; SQR->MUL when square completes and current exponent bit is 1; SQR->SQR (next bit) never occurs (every bit 6..1 is 1); SQR->FIN after the bit-0 square; MUL->SQR after multiply completes; FIN->IDLE unconditionally after one cycle.
REQ-019 done=1 only in FIN; busy=0 in IDLE and FIN.
REQ-020 A start asserted in the FIN cycle SHALL be accepted (back-to-back operation, 106-cycle period).
REQ-021 inv_out and zero_err SHALL update in the FIN cycle and hold until the next done.
REQ-022 Operand 0x00 SHALL produce inv_out=0x00 and zero_err=1; nonzero operands give zero_err=0.
REQ-023 Multiplier reduction: on each shift, if bit 8 is set, XOR with POLY (9-bit).

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, inv_out=8'h00, zero_err=0, and clear operand, accumulator, and bit counters.
REQ-025 rst asserted mid-operation SHALL abort; no done pulse for the aborted operation.
REQ-026 rst has priority over start in the same cycle.

Structure
REQ-027 POLY default, field width (8), exponent constant 8'hFE, and FSM state encoding SHALL live in a shared gf8 package for reuse by the other GF(2^8) blocks.
REQ-028 The serial multiplier SHALL be a separate sub-module gf8_mul_serial (ports: clk, rst, go, x, y, p, rdy), 8-cycle latency, reusable in the multipliers library.
REQ-029 No combinational path from start or a_in to any output.

Verification
REQ-030 a_in=0x53, start pulse -> done exactly 105 cycles later, inv_out=0xCA, zero_err=0.
REQ-031 a_in=0x01 -> inv_out=0x01; a_in=0x02 -> inv_out=0x8D; a_in=0xFF -> inv_out=0x1C.
REQ-032 a_in=0x00 -> inv_out=0x00, zero_err=1, same 105-cycle latency.
REQ-033 start=1 with a_in=0x07 at cycle 40 of an operation on 0x53 -> result still 0xCA, no extra done, busy unaffected.
REQ-034 rst pulse at cycle 50 of an operation -> outputs zero next cycle, no done; fresh start then completes correctly.
REQ-035 Exhaustive back-to-back sweep a=0x01..0xFF, start held high -> each done spaced 106 cycles, model check gf_mul(a,inv_out)=0x01 for all.
